// File: rtl/pwm_capture32.sv
// rtl/pwm_capture32.sv - PWM input capture: high time and period in prescaled ticks
// Back-to-back capture with optional timeout; results update together on o_valid.
module pwm_capture32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pre,
  input  logic [31:0] i_tmo,
  input  logic        i_capen,
  input  logic        i_clr_to,
  input  logic        i_pwm_in,
  output logic [31:0] o_high_time,
  output logic [31:0] o_period,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [31:0] r_clkdiv;
  logic [31:0] r_cnt;
  logic [31:0] r_hlat;
  logic [31:0] r_high_time;
  logic [31:0] r_period;
  logic        r_valid;
  logic        r_timeout;

  logic        w_rise;
  logic        w_fall;
  logic        w_tick;
  logic [31:0] w_nxt;
  logic [31:0] w_clkdiv_nxt;
  logic        w_to_hit;

  // Rise and fall share the same two-edge latency, so durations are exact.
  assign w_rise       = r_s2 & ~r_s3;
  assign w_fall       = ~r_s2 & r_s3;
  assign w_tick       = (r_clkdiv == i_pre);
  assign w_nxt        = (w_tick && (r_cnt != 32'hFFFF_FFFF)) ? r_cnt + 32'd1 : r_cnt;
  assign w_clkdiv_nxt = w_tick ? 32'd0 : r_clkdiv + 32'd1;
  assign w_to_hit     = (i_tmo != 32'd0) && w_tick && (r_cnt == i_tmo);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_clkdiv    <= 32'd0;
      r_cnt       <= 32'd0;
      r_hlat      <= 32'd0;
      r_high_time <= 32'd0;
      r_period    <= 32'd0;
      r_valid     <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_s1    <= i_pwm_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_valid <= 1'b0;
      if (i_clr_to) r_timeout <= 1'b0;

      if (!i_capen) begin
        r_state  <= ST_IDLE;
        r_clkdiv <= 32'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_clkdiv <= 32'd0;
            r_state  <= ST_WAIT_RISE;
          end
          ST_WAIT_RISE: begin
            r_clkdiv <= 32'd0;
            if (w_rise) begin
              r_cnt   <= 32'd0;
              r_state <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (w_fall) begin
              r_hlat   <= w_nxt;
              r_cnt    <= w_nxt;
              r_clkdiv <= w_clkdiv_nxt;
              r_state  <= ST_LOW;
            end else if (w_to_hit) begin
              r_timeout <= 1'b1;
              r_clkdiv  <= 32'd0;
              r_state   <= ST_WAIT_RISE;
            end else begin
              r_cnt    <= w_nxt;
              r_clkdiv <= w_clkdiv_nxt;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_high_time <= r_hlat;
              r_period    <= w_nxt;
              r_valid     <= 1'b1;
              r_cnt       <= 32'd0;
              r_clkdiv    <= 32'd0;
              r_state     <= ST_HIGH;
            end else if (w_to_hit) begin
              r_timeout <= 1'b1;
              r_clkdiv  <= 32'd0;
              r_state   <= ST_WAIT_RISE;
            end else begin
              r_cnt    <= w_nxt;
              r_clkdiv <= w_clkdiv_nxt;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_high_time = r_high_time;
  assign o_period    = r_period;
  assign o_valid     = r_valid;
  assign o_busy      = (r_state == ST_HIGH) || (r_state == ST_LOW);
  assign o_timeout   = r_timeout;

endmodule
